// File: rtl/sync_down_counter_pkg.sv
// Shared types and constants for the sync_down_counter timer/divider stage.
// Optional up/down counting is built in when SYNC_DOWN_COUNTER_UPDN_EN is defined.
package sync_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int unsigned RESET_COUNT = 0;

endpackage

// File: rtl/sdc_next.sv
// Combinational next-count, expiry and terminal-count logic for sync_down_counter.
// SYNC_DOWN_COUNTER_UPDN_EN adds the up input selecting upward counting.
module sdc_next
    import sync_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             run,
    input  logic             oneshot,
`ifdef SYNC_DOWN_COUNTER_UPDN_EN
    input  logic             up,
`endif
    output logic [WIDTH-1:0] q_next,
    output logic             expire,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO = WIDTH'(RESET_COUNT);
    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULUS - 1);

    logic             at_end;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] wrap;

    always_comb begin
        at_end = (q == ZERO);
        step   = q - WIDTH'(1);
        wrap   = TOP;
`ifdef SYNC_DOWN_COUNTER_UPDN_EN
        if (up) begin
            at_end = (q == TOP);
            step   = q + WIDTH'(1);
            wrap   = ZERO;
        end
`endif
        tc     = run & en & at_end;
        expire = tc & oneshot;

        // Step only away from the end value, so no arithmetic overflow is possible.
        q_next = q;
        if (run && en) begin
            if (!at_end) begin
                q_next = step;
            end else if (!oneshot) begin
                q_next = wrap;
            end
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// Loadable modulo-MODULUS down counter with wrap/one-shot modes and cascadable tc.
// Defining SYNC_DOWN_COUNTER_UPDN_EN adds the up port for bidirectional counting.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
`ifdef SYNC_DOWN_COUNTER_UPDN_EN
    input  logic             up,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done,
    output logic             busy,
    output state_t           state
);

    state_t           state_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] load_q;
    logic             expire;

    sdc_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q       (q),
        .en      (en),
        .run     (state == RUN),
        .oneshot (oneshot),
`ifdef SYNC_DOWN_COUNTER_UPDN_EN
        .up      (up),
`endif
        .q_next  (q_next),
        .expire  (expire),
        .tc      (tc)
    );

    // Widened compare so MODULUS == 2**WIDTH never clamps.
    assign load_q = ({1'b0, load_val} < (WIDTH + 1)'(MODULUS)) ? load_val : WIDTH'(MODULUS - 1);

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = RUN;
        end else if (expire) begin
            state_next = HALT;
        end
    end

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            state <= IDLE;
            q     <= WIDTH'(RESET_COUNT);
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= expire & ~load;
            q     <= load ? load_q : q_next;
        end
    end

endmodule

// File: tb/tb_sync_down_counter.sv
// Scenario bench for sync_down_counter: reset, wrap, one-shot, clamp, async reset, cascade.
// Built for the default configuration; SYNC_DOWN_COUNTER_UPDN_EN ties up low.
module tb_sync_down_counter;
    import sync_down_counter_pkg::*;

    localparam int W = 10;

    logic       clk = 1'b0;
    logic       ar  = 1'b1;
    logic       en = 1'b0, load = 1'b0, oneshot = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q;
    logic       tc, done, busy;
    state_t     st;

    logic       c_en = 1'b0, c_load = 1'b0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_done, hi_done, lo_busy, hi_busy;
    state_t     lo_st, hi_st;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_down_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .ar(ar), .en(en), .load(load), .load_val(load_val), .oneshot(oneshot),
`ifdef SYNC_DOWN_COUNTER_UPDN_EN
        .up(1'b0),
`endif
        .q(q), .tc(tc), .done(done), .busy(busy), .state(st)
    );

    sync_down_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .ar(ar), .en(c_en), .load(c_load), .load_val(4'd0), .oneshot(1'b0),
`ifdef SYNC_DOWN_COUNTER_UPDN_EN
        .up(1'b0),
`endif
        .q(lo_q), .tc(lo_tc), .done(lo_done), .busy(lo_busy), .state(lo_st)
    );

    sync_down_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .ar(ar), .en(lo_tc), .load(c_load), .load_val(4'd0), .oneshot(1'b0),
`ifdef SYNC_DOWN_COUNTER_UPDN_EN
        .up(1'b0),
`endif
        .q(hi_q), .tc(hi_tc), .done(hi_done), .busy(hi_busy), .state(hi_st)
    );

    function automatic logic [W-1:0] pk(int eq, logic etc, logic edone, logic ebusy, state_t es);
        return {1'b0, 4'(eq), etc, edone, ebusy, 2'(es)};
    endfunction

    function automatic logic [6:0] sv(logic l, int v, logic e, logic o);
        return {l, 4'(v), e, o};
    endfunction

    function automatic logic [W-1:0] snap();
        return {1'b0, q, tc, done, busy, 2'(st)};
    endfunction

    function automatic string fmt(logic [W-1:0] v);
        return $sformatf("q=%0d tc=%b done=%b busy=%b state=%0d", v[8:5], v[4], v[3], v[2], v[1:0]);
    endfunction

    // Inputs change 1ns after the rising edge; the snapshot is taken on the falling edge.
    task automatic drive(input logic [6:0] s);
        @(posedge clk);
        #1;
        {load, load_val, en, oneshot} = s;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [W-1:0] got, exp;
        #1;
        exp_q.push_back(pk(0, 0, 0, 0, IDLE));
        got = snap();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_immediate: got %s expected %s", fmt(got), fmt(exp));
        end
        @(negedge clk);
        ar = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(pk(0, 0, 0, 0, IDLE));
            drive(sv(0, 0, 1, 0));
            got = snap();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_wrap();
        logic [6:0]   stim[$];
        logic [W-1:0] got, exp;
        stim.push_back(sv(1, 3, 1, 0)); exp_q.push_back(pk(0, 0, 0, 0, IDLE));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(3, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(2, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(1, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(0, 1, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(9, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(8, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 0, 0)); exp_q.push_back(pk(7, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 0, 0)); exp_q.push_back(pk(7, 0, 0, 1, RUN));
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i]);
            got = snap();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wrap[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_oneshot();
        logic [6:0]   stim[$];
        logic [W-1:0] got, exp;
        stim.push_back(sv(1, 2, 1, 1)); exp_q.push_back(pk(7, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 1)); exp_q.push_back(pk(2, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 1)); exp_q.push_back(pk(1, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 1)); exp_q.push_back(pk(0, 1, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 1)); exp_q.push_back(pk(0, 0, 1, 0, HALT));
        stim.push_back(sv(0, 0, 1, 1)); exp_q.push_back(pk(0, 0, 0, 0, HALT));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(0, 0, 0, 0, HALT));
        stim.push_back(sv(1, 4, 1, 1)); exp_q.push_back(pk(0, 0, 0, 0, HALT));
        stim.push_back(sv(0, 0, 0, 1)); exp_q.push_back(pk(4, 0, 0, 1, RUN));
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i]);
            got = snap();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL oneshot[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_clamp_priority();
        logic [6:0]   stim[$];
        logic [W-1:0] got, exp;
        stim.push_back(sv(1, 13, 1, 0)); exp_q.push_back(pk(4, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0));  exp_q.push_back(pk(9, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0));  exp_q.push_back(pk(8, 0, 0, 1, RUN));
        stim.push_back(sv(1, 0, 1, 0));  exp_q.push_back(pk(7, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0));  exp_q.push_back(pk(0, 1, 0, 1, RUN));
        stim.push_back(sv(0, 0, 0, 0));  exp_q.push_back(pk(9, 0, 0, 1, RUN));
        stim.push_back(sv(1, 10, 0, 0)); exp_q.push_back(pk(9, 0, 0, 1, RUN));
        stim.push_back(sv(1, 5, 0, 0));  exp_q.push_back(pk(9, 0, 0, 1, RUN));
        stim.push_back(sv(1, 9, 0, 0));  exp_q.push_back(pk(5, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 0, 0));  exp_q.push_back(pk(9, 0, 0, 1, RUN));
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i]);
            got = snap();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clamp[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [6:0]   stim[$];
        logic [W-1:0] got, exp;
        stim.push_back(sv(1, 7, 0, 0)); exp_q.push_back(pk(9, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(7, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(6, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(5, 0, 0, 1, RUN));
        stim.push_back(sv(0, 0, 1, 0)); exp_q.push_back(pk(4, 0, 0, 1, RUN));
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i]);
            got = snap();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_run[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
        // Mid-cycle reset: no clock edge between assertion and the check.
        #1;
        ar = 1'b1;
        exp_q.push_back(pk(0, 0, 0, 0, IDLE));
        #1;
        got = snap();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_immediate: got %s expected %s", fmt(got), fmt(exp));
        end
        #1;
        ar = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pk(0, 0, 0, 0, IDLE));
            drive(sv(0, 0, 1, 0));
            got = snap();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_idle[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_cascade();
        logic [W-1:0] got, exp;
        int           val;
        for (int k = 0; k < 23; k++) begin
            val = (k == 0) ? 0 : (101 - k) % 100;
            exp_q.push_back({(k > 0) && (val % 10 == 0), (k > 0) && (val == 0), 1'b0, 7'(val)});
            @(posedge clk);
            #1;
            c_en   = 1'b1;
            c_load = (k == 0);
            @(negedge clk);
            got = {lo_tc, hi_tc, lo_done | hi_done, 7'(int'(hi_q) * 10 + int'(lo_q))};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cascade[%0d]: got pair=%0d lo_tc=%b hi_tc=%b done=%b expected pair=%0d lo_tc=%b hi_tc=%b done=%b",
                         k, got[6:0], got[9], got[8], got[7], exp[6:0], exp[9], exp[8], exp[7]);
            end
        end
        c_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_oneshot();
        test_clamp_priority();
        test_async_reset();
        test_cascade();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
